// File: rtl/pkt_rr_arbiter.sv
`default_nettype none
// ============================================================================
// pkt_rr_arbiter : round-robin burst arbiter that stamps words for the checker
// Optional feature macro: PKT_ARB_PRIO_EN (source 0 becomes high priority)
// Revision: 1.0
// ============================================================================
module pkt_rr_arbiter #(
  parameter int BUS_SIZE  = 16,
  parameter int WORD_SIZE = 4,
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2,
  parameter int BURST_LEN = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_last,
  input  logic [NUM_REQ*BUS_SIZE-1:0] req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        chk_error,
  output logic [BUS_SIZE-1:0]         bus_data_out,
  output logic                        bus_valid,
  output logic [ID_W-1:0]             grant_id,
  output logic                        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    RECOVER = 2'd2
  } state_t;

  localparam int MID_W = BUS_SIZE - 2*WORD_SIZE;
  localparam logic [WORD_SIZE-1:0] HDR       = {WORD_SIZE{1'b1}};
  localparam logic [WORD_SIZE-1:0] LSW_FIRST = WORD_SIZE'(1);
  localparam logic [WORD_SIZE-1:0] LSW_NEXT  = WORD_SIZE'(2);
  localparam logic [3:0]           CNT_LAST  = 4'(BURST_LEN-1);
  localparam logic [ID_W-1:0]      ID_LAST   = ID_W'(NUM_REQ-1);

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [3:0]        word_cnt;
  logic [ID_W-1:0]   winner;
  logic              any_valid;
  logic [ID_W-1:0]   next_ptr;
  logic              burst_end;
  logic [MID_W-1:0]  sel_mid;

  // Descending scan so the lowest offset from rr_ptr is the final assignment.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[idx]) begin
        winner    = ID_W'(idx);
        any_valid = 1'b1;
      end
    end
`ifdef PKT_ARB_PRIO_EN
    if (req_valid[0]) begin
      winner    = '0;
      any_valid = 1'b1;
    end
`endif
  end

  always_comb begin
    next_ptr = (grant_id == ID_LAST) ? '0 : grant_id + 1'b1;
`ifdef PKT_ARB_PRIO_EN
    // High-priority bursts must not disturb the rotation of the others.
    if (grant_id == '0) next_ptr = rr_ptr;
`endif
  end

  always_comb begin
    req_ready = '0;
    if (state == SEND && !chk_error) req_ready[grant_id] = 1'b1;
  end

  assign burst_end = req_last[grant_id] || (word_cnt == CNT_LAST);
  assign sel_mid   = req_data[int'(grant_id)*BUS_SIZE + WORD_SIZE +: MID_W];
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      grant_id     <= '0;
      word_cnt     <= '0;
      bus_data_out <= '0;
      bus_valid    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus_valid <= 1'b0;
          if (any_valid) begin
            grant_id <= winner;
            word_cnt <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (chk_error) begin
            bus_valid <= 1'b0;
            rr_ptr    <= next_ptr;
            word_cnt  <= '0;
            state     <= RECOVER;
          end else if (req_valid[grant_id]) begin
            bus_data_out <= {HDR, sel_mid, (word_cnt == '0) ? LSW_FIRST : LSW_NEXT};
            bus_valid    <= 1'b1;
            if (burst_end) begin
              rr_ptr   <= next_ptr;
              word_cnt <= '0;
              state    <= IDLE;
            end else begin
              word_cnt <= word_cnt + 4'd1;
            end
          end else begin
            bus_valid <= 1'b0;
          end
        end
        RECOVER: begin
          bus_valid <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          bus_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pkt_rr_arbiter.sv
`default_nettype none
// ============================================================================
// tb_pkt_rr_arbiter : directed self-checking bench for pkt_rr_arbiter
// Revision: 1.0
// ============================================================================
module tb_pkt_rr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_last;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        chk_error;
  logic [15:0] bus_data_out;
  logic        bus_valid;
  logic [1:0]  grant_id;
  logic        busy;

  int passed = 0;
  int total  = 0;

  pkt_rr_arbiter #(
    .BUS_SIZE (16),
    .WORD_SIZE(4),
    .NUM_REQ  (4),
    .ID_W     (2),
    .BURST_LEN(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .chk_error   (chk_error),
    .bus_data_out(bus_data_out),
    .bus_valid   (bus_valid),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic set_data(input int i, input logic [15:0] v);
    req_data[i*16 +: 16] = v;
  endtask

  initial begin
    logic [31:0] exp;
    int          s;
    int          first_src;
    int          second_src;

    reset     = 1'b0;
    req_valid = 4'hF;
    req_last  = 4'h0;
    req_data  = '0;
    chk_error = 1'b0;
    for (int i = 0; i < 4; i++) set_data(i, 16'(i * 16'h0110));

    // Reset held with all sources requesting
    tick(); tick();
    chk("rst_data",  32'(bus_data_out), 32'h0);
    chk("rst_valid", 32'(bus_valid),    32'h0);
    chk("rst_grant", 32'(grant_id),     32'h0);
    chk("rst_busy",  32'(busy),         32'h0);
    chk("rst_ready", 32'(req_ready),    32'h0);
    req_valid = 4'h0;
    reset     = 1'b1;
    tick();

    // Source 2 alone, three-word packet
    set_data(2, 16'h1234);
    req_valid = 4'b0100;
    tick();
    chk("t2_grant", 32'(grant_id), 32'd2);
    chk("t2_busy",  32'(busy),     32'd1);
    #1 chk("t2_ready", 32'(req_ready), 32'b0100);
    tick();
    chk("t2_w1", 32'(bus_data_out), 32'hF231);
    chk("t2_v1", 32'(bus_valid),    32'd1);
    set_data(2, 16'h5678);
    tick();
    chk("t2_w2", 32'(bus_data_out), 32'hF672);
    set_data(2, 16'h9ABC);
    req_last = 4'b0100;
    tick();
    chk("t2_w3", 32'(bus_data_out), 32'hFAB2);
    chk("t2_v3", 32'(bus_valid),    32'd1);
    req_valid = 4'h0;
    req_last  = 4'h0;
    tick();
    chk("t2_v_end",    32'(bus_valid), 32'd0);
    chk("t2_busy_end", 32'(busy),      32'd0);

    // All sources streaming: rotation resumes from source 3
    set_data(2, 16'h0220);
    req_valid = 4'hF;
    for (int b = 0; b < 5; b++) begin
      s = (3 + b) % 4;
      tick();
      chk("t3_grant", 32'(grant_id),  32'(s));
      chk("t3_gap",   32'(bus_valid), 32'd0);
      for (int w = 0; w < 4; w++) begin
        tick();
        exp = 32'hF000 + 32'(s) * 32'h110 + ((w == 0) ? 32'd1 : 32'd2);
        chk("t3_word",  32'(bus_data_out), exp);
        chk("t3_valid", 32'(bus_valid),    32'd1);
        if (b == 4 && w == 3) req_valid = 4'h0;
      end
    end
    tick();
    chk("t3_idle", 32'(busy), 32'd0);

    // Checker error during second word of a source-1 burst
    req_valid = 4'b0110;
    tick();
    chk("t4_grant1", 32'(grant_id), 32'd1);
    tick();
    chk("t4_w1", 32'(bus_data_out), 32'hF111);
    chk("t4_v1", 32'(bus_valid),    32'd1);
    chk_error = 1'b1;
    #1 chk("t4_ready_err", 32'(req_ready), 32'h0);
    tick();
    chk("t4_rec_valid", 32'(bus_valid), 32'd0);
    chk("t4_rec_busy",  32'(busy),      32'd1);
    chk_error = 1'b0;
    #1 chk("t4_rec_ready", 32'(req_ready), 32'h0);
    tick();
    chk("t4_idle_busy",  32'(busy),      32'd0);
    chk("t4_idle_valid", 32'(bus_valid), 32'd0);
    tick();
    chk("t4_grant2", 32'(grant_id), 32'd2);
    tick();
    chk("t4_s2_w1", 32'(bus_data_out), 32'hF221);
    req_last = 4'b0100;
    tick();
    chk("t4_s2_w2", 32'(bus_data_out), 32'hF222);
    req_valid = 4'h0;
    req_last  = 4'h0;
    tick();
    chk("t4_end_busy", 32'(busy), 32'd0);

    // Source 0 stalls for three cycles mid-burst
    set_data(0, 16'h4560);
    req_valid = 4'b0001;
    tick();
    chk("t5_grant", 32'(grant_id), 32'd0);
    tick();
    chk("t5_w1", 32'(bus_data_out), 32'hF561);
    req_valid = 4'h0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t5_stall_valid", 32'(bus_valid), 32'd0);
      chk("t5_stall_grant", 32'(grant_id),  32'd0);
    end
    req_valid = 4'b0001;
    set_data(0, 16'h7890);
    tick();
    chk("t5_w2", 32'(bus_data_out), 32'hF892);
    chk("t5_v2", 32'(bus_valid),    32'd1);
    set_data(0, 16'hABC0);
    req_last = 4'b0001;
    tick();
    chk("t5_w3", 32'(bus_data_out), 32'hFBC2);
    req_valid = 4'h0;
    req_last  = 4'h0;
    tick();
    chk("t5_end_busy", 32'(busy), 32'd0);

    // Move pointer to 2 with a one-word source-1 burst, then 0 and 2 compete
    req_valid = 4'b0010;
    req_last  = 4'b0010;
    tick();
    chk("t6_grant1", 32'(grant_id), 32'd1);
    tick();
    chk("t6_s1_w", 32'(bus_data_out), 32'hF111);
    req_valid = 4'b0101;
    req_last  = 4'b0101;
`ifdef PKT_ARB_PRIO_EN
    first_src  = 0;
    second_src = 2;
`else
    first_src  = 2;
    second_src = 0;
`endif
    tick();
    chk("t6_first_grant", 32'(grant_id), 32'(first_src));
    tick();
    chk("t6_first_word", 32'(bus_data_out), (first_src == 0) ? 32'hFBC1 : 32'hF221);
    tick();
    chk("t6_second_grant", 32'(grant_id), 32'(second_src));
    tick();
    chk("t6_second_word", 32'(bus_data_out), (second_src == 0) ? 32'hFBC1 : 32'hF221);
    req_valid = 4'h0;
    req_last  = 4'h0;
    tick();

    // Asynchronous reset in the middle of a source-3 burst
    req_valid = 4'b1000;
    tick();
    chk("t1b_grant", 32'(grant_id), 32'd3);
    tick();
    chk("t1b_w1", 32'(bus_data_out), 32'hF331);
    chk("t1b_v1", 32'(bus_valid),    32'd1);
    #2 reset = 1'b0;
    #1;
    chk("t1b_valid", 32'(bus_valid),    32'd0);
    chk("t1b_data",  32'(bus_data_out), 32'h0);
    chk("t1b_grant0", 32'(grant_id),    32'd0);
    chk("t1b_busy",  32'(busy),         32'd0);
    chk("t1b_ready", 32'(req_ready),    32'h0);
    tick();
    reset     = 1'b1;
    req_valid = 4'h0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
